// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard controller.
//   RD_W       : register-index width carried in a tracker slot
//   SEL_*      : EX-stage forwarding mux select codes (2'b11 is never used)
//   state_t    : controller FSM states
//   slot_t     : destination-register tracker for one pipeline slot
package fwd_pkg;

  localparam int RD_W = 5;

  localparam logic [1:0] SEL_EX  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FREEZE     = 2'd2
  } state_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } slot_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority compare of one ID-stage source register against the producers
// that will sit in MEM and WB when this instruction reaches EX.
//   rs, rs_used          : source register index and "is read" flag
//   ex_rd, ex_regwrite   : current ID/EX producer (becomes MEM next cycle)
//   mem_rd, mem_regwrite : current EX/MEM producer (becomes WB next cycle)
//   sel                  : SEL_MEM / SEL_WB / SEL_EX (combinational)
module fwd_sel_calc
  import fwd_pkg::*;
#(
  parameter int REG_AW = RD_W
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  output logic [1:0]        sel
);

  // The youngest producer wins; x0 is never a forwarding source.
  always_comb begin
    sel = SEL_EX;
    if (rs_used && ex_regwrite && (ex_rd != '0) && (rs == ex_rd)) begin
      sel = SEL_MEM;
    end else if (rs_used && mem_regwrite && (mem_rd != '0) && (rs == mem_rd)) begin
      sel = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline.
// Tracks {rd, regwrite, memread} for the ID/EX, EX/MEM and MEM/WB slots,
// registers the EX-stage operand A/B forwarding selects, detects load-use
// hazards (stall + bubble), and honours memory freezes and branch flushes.
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   rs1_id_i/rs2_id_i, rs*_used_i : ID-stage sources and their use flags
//   rd_id_i, regwrite_id_i, memread_id_i : ID-stage destination info
//   flush_i                       : squash the ID instruction (branch taken)
//   mem_stall_i                   : freeze the whole pipeline
//   fwdA_sel_o, fwdB_sel_o        : registered forwarding mux selects
//   stall_o, bubble_o             : hold PC/IF-ID, load NOP into ID/EX
// Optional build macro FWD_STATS_EN adds saturating counters
//   stall_cnt_o, fwd_cnt_o, freeze_cnt_o.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = RD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_id_i,
  input  logic [REG_AW-1:0] rs2_id_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [REG_AW-1:0] rd_id_i,
  input  logic              regwrite_id_i,
  input  logic              memread_id_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic [1:0]        fwdA_sel_o,
  output logic [1:0]        fwdB_sel_o,
  output logic              stall_o,
  output logic              bubble_o
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       fwd_cnt_o,
  output logic [31:0]       freeze_cnt_o
`endif
);

  state_t     state_q, state_d;
  slot_t      trk_p0, trk_p1, trk_p2;
  logic       load_use;
  logic       advance;
  logic       insert_bubble;
  logic [1:0] sel_a_calc, sel_b_calc;
  logic [1:0] sel_a_d, sel_b_d;

  // The MEM/WB slot completes the pipeline model but no decision reads it.
  logic unused_wb;
  assign unused_wb = ^trk_p2;

  assign load_use = trk_p0.memread && (trk_p0.rd != '0) &&
                    ((rs1_used_i && (rs1_id_i == trk_p0.rd)) ||
                     (rs2_used_i && (rs2_id_i == trk_p0.rd)));

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
    .rs           (rs1_id_i),
    .rs_used      (rs1_used_i),
    .ex_rd        (trk_p0.rd),
    .ex_regwrite  (trk_p0.regwrite),
    .mem_rd       (trk_p1.rd),
    .mem_regwrite (trk_p1.regwrite),
    .sel          (sel_a_calc)
  );

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
    .rs           (rs2_id_i),
    .rs_used      (rs2_used_i),
    .ex_rd        (trk_p0.rd),
    .ex_regwrite  (trk_p0.regwrite),
    .mem_rd       (trk_p1.rd),
    .mem_regwrite (trk_p1.regwrite),
    .sel          (sel_b_calc)
  );

  // Priority: memory freeze, then flush, then load-use hazard.
  always_comb begin
    stall_o       = 1'b0;
    bubble_o      = 1'b0;
    advance       = 1'b1;
    insert_bubble = 1'b0;
    if (mem_stall_i) begin
      stall_o = 1'b1;
      advance = 1'b0;
    end else if (flush_i) begin
      bubble_o      = 1'b1;
      insert_bubble = 1'b1;
    end else if (load_use) begin
      stall_o       = 1'b1;
      bubble_o      = 1'b1;
      insert_bubble = 1'b1;
    end
  end

  // A bubble entering ID/EX carries no operands, so nothing forwards to it.
  assign sel_a_d = insert_bubble ? SEL_EX : sel_a_calc;
  assign sel_b_d = insert_bubble ? SEL_EX : sel_b_calc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall_i)                 state_d = FREEZE;
        else if (load_use && !flush_i)   state_d = LOAD_STALL;
      end
      LOAD_STALL: state_d = mem_stall_i ? FREEZE : RUN;
      FREEZE:     state_d = mem_stall_i ? FREEZE : RUN;
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- ID/EX -> EX/MEM -> MEM/WB tracker stages and EX-stage selects ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_p0     <= '0;
      trk_p1     <= '0;
      trk_p2     <= '0;
      fwdA_sel_o <= SEL_EX;
      fwdB_sel_o <= SEL_EX;
    end else if (advance) begin
      trk_p2     <= trk_p1;
      trk_p1     <= trk_p0;
      trk_p0     <= insert_bubble ? slot_t'('0)
                                  : slot_t'{rd: rd_id_i, regwrite: regwrite_id_i,
                                            memread: memread_id_i};
      fwdA_sel_o <= sel_a_d;
      fwdB_sel_o <= sel_b_d;
    end
  end

`ifdef FWD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      fwd_cnt_o    <= '0;
      freeze_cnt_o <= '0;
    end else begin
      if (!mem_stall_i && !flush_i && load_use) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (advance && ((sel_a_d != SEL_EX) || (sel_b_d != SEL_EX)))
        fwd_cnt_o <= sat_inc(fwd_cnt_o);
      if (mem_stall_i) freeze_cnt_o <= sat_inc(freeze_cnt_o);
    end
  end
`endif

endmodule
